// File: rtl/awmf0165_pkg.sv
// ---------------------------------------------------------------------------
// awmf0165_pkg
// Shared definitions for the AWMF-0165 chain responder: chain geometry,
// bit-counter width, FSM state encoding and the saturating counter helper.
// ---------------------------------------------------------------------------
package awmf0165_pkg;

    localparam int N_DEV      = 5;
    localparam int DEV_BITS   = 48;
    localparam int FRAME_BITS = N_DEV * DEV_BITS;
    localparam int CNT_W      = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Increment that sticks at all-ones so very long frames cannot wrap back
    // to a count that looks valid.
    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/awmf_sync_edge.sv
// ---------------------------------------------------------------------------
// awmf_sync_edge
// Two-flop synchronizer for one asynchronous input followed by a history
// flop that yields single-cycle rise/fall pulses.
// Ports:
//   clk   in   sampling clock
//   rst   in   synchronous, active-high reset (flops go to RST_VAL)
//   din   in   asynchronous input pin
//   level out  synchronized level
//   rise  out  1-cycle pulse on a synchronized 0->1 transition
//   fall  out  1-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module awmf_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/awmf0165_chain_responder.sv
// ---------------------------------------------------------------------------
// awmf0165_chain_responder
// Behaves like the tail of a 5 x 48-bit AWMF-0165 daisy chain: shifts a
// frame in from the master, drives sdo from the shift-register MSB, and
// copies the shift register into a latch on an ldb rising edge.
// Ports:
//   clk_20m      in   system clock
//   rst          in   synchronous, active-high reset
//   awmf_clk_i   in   serial clock from master (asynchronous)
//   awmf_csb_i   in   chip select, active low
//   awmf_sdi_i   in   serial data in, MSB first
//   awmf_pdi_i   in   frame type at csb fall (1 = read)
//   awmf_ldb_i   in   load strobe, rising edge latches while idle
//   awmf_sdo_o   out  serial data out
//   latch_data_o out  last latched frame
//   latch_vld_o  out  pulse when latch_data_o updates
//   frame_done_o out  pulse at the end of each frame
//   frame_err_o  out  sticky bit-count error of the last frame
//   rd_frame_o   out  frame type of current/last frame
//   bit_cnt_o    out  bits shifted in current/last frame
// ---------------------------------------------------------------------------
module awmf0165_chain_responder
    import awmf0165_pkg::*;
(
    input  logic                  clk_20m,
    input  logic                  rst,
    input  logic                  awmf_clk_i,
    input  logic                  awmf_csb_i,
    input  logic                  awmf_sdi_i,
    input  logic                  awmf_pdi_i,
    input  logic                  awmf_ldb_i,
    output logic                  awmf_sdo_o,
    output logic [FRAME_BITS-1:0] latch_data_o,
    output logic                  latch_vld_o,
    output logic                  frame_done_o,
    output logic                  frame_err_o,
    output logic                  rd_frame_o,
    output logic [CNT_W-1:0]      bit_cnt_o
);

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic csb_lvl_s,  csb_rise_s,  csb_fall_s;
    logic sdi_lvl_s,  sdi_rise_s,  sdi_fall_s;
    logic pdi_lvl_s,  pdi_rise_s,  pdi_fall_s;
    logic ldb_lvl_s,  ldb_rise_s,  ldb_fall_s;
    logic unused_s;

    // csb resets low so that a reset taken mid-frame never sees a fresh
    // csb fall: the rest of that frame stays ignored until csb toggles.
    awmf_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (.clk(clk_20m), .rst(rst), .din(awmf_clk_i),
        .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
    awmf_sync_edge #(.RST_VAL(1'b0)) u_sync_csb (.clk(clk_20m), .rst(rst), .din(awmf_csb_i),
        .level(csb_lvl_s), .rise(csb_rise_s), .fall(csb_fall_s));
    awmf_sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (.clk(clk_20m), .rst(rst), .din(awmf_sdi_i),
        .level(sdi_lvl_s), .rise(sdi_rise_s), .fall(sdi_fall_s));
    awmf_sync_edge #(.RST_VAL(1'b0)) u_sync_pdi (.clk(clk_20m), .rst(rst), .din(awmf_pdi_i),
        .level(pdi_lvl_s), .rise(pdi_rise_s), .fall(pdi_fall_s));
    awmf_sync_edge #(.RST_VAL(1'b0)) u_sync_ldb (.clk(clk_20m), .rst(rst), .din(awmf_ldb_i),
        .level(ldb_lvl_s), .rise(ldb_rise_s), .fall(ldb_fall_s));

    // Edge/level outputs this block has no use for.
    assign unused_s = ^{sclk_lvl_s, csb_lvl_s, sdi_rise_s, sdi_fall_s,
                        pdi_rise_s, pdi_fall_s, ldb_lvl_s, ldb_fall_s};

    state_t                 state_r, state_nxt_s;
    logic [FRAME_BITS-1:0]  shift_r;
    logic                   do_start_s, do_shift_s, do_sdo_s, do_done_s, do_latch_s;

    // State register.
    always_ff @(posedge clk_20m) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes; a csb edge always wins over a clk
    // edge in the same cycle, which drops that clk edge.
    always_comb begin
        state_nxt_s = state_r;
        do_start_s  = 1'b0;
        do_shift_s  = 1'b0;
        do_sdo_s    = 1'b0;
        do_done_s   = 1'b0;
        do_latch_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (csb_fall_s) begin
                    state_nxt_s = SHIFT;
                    do_start_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
                if (ldb_rise_s) begin
                    do_latch_s = 1'b1;
                end else begin
                    do_latch_s = 1'b0;
                end
            end
            SHIFT: begin
                if (csb_rise_s) begin
                    state_nxt_s = DONE;
                    do_done_s   = 1'b1;
                end else begin
                    state_nxt_s = SHIFT;
                    do_shift_s  = sclk_rise_s;
                    do_sdo_s    = sclk_fall_s;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Shift register, counter, latch and all registered outputs.
    always_ff @(posedge clk_20m) begin
        if (rst) begin
            shift_r      <= {FRAME_BITS{1'b0}};
            latch_data_o <= {FRAME_BITS{1'b0}};
            awmf_sdo_o   <= 1'b0;
            latch_vld_o  <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            rd_frame_o   <= 1'b0;
            bit_cnt_o    <= {CNT_W{1'b0}};
        end else begin
            latch_vld_o  <= do_latch_s;
            frame_done_o <= do_done_s;
            if (do_latch_s) begin
                latch_data_o <= shift_r;
            end
            if (do_start_s) begin
                bit_cnt_o   <= {CNT_W{1'b0}};
                frame_err_o <= 1'b0;
                rd_frame_o  <= pdi_lvl_s;
                // Preload sdo so the master's first clk rise already sees the MSB.
                if (pdi_lvl_s) begin
                    shift_r    <= latch_data_o;
                    awmf_sdo_o <= latch_data_o[FRAME_BITS-1];
                end else begin
                    awmf_sdo_o <= shift_r[FRAME_BITS-1];
                end
            end else if (do_shift_s) begin
                shift_r   <= {shift_r[FRAME_BITS-2:0], sdi_lvl_s};
                bit_cnt_o <= cnt_inc_sat(bit_cnt_o);
            end else if (do_sdo_s) begin
                awmf_sdo_o <= shift_r[FRAME_BITS-1];
            end
            if (do_done_s) begin
                frame_err_o <= (bit_cnt_o != CNT_W'(FRAME_BITS));
            end
        end
    end

endmodule

// File: tb/tb_awmf0165_chain_responder.sv
module tb_awmf0165_chain_responder;
    import awmf0165_pkg::*;

    logic                  clk_20m    = 1'b0;
    logic                  rst        = 1'b1;
    logic                  awmf_clk_i = 1'b0;
    logic                  awmf_csb_i = 1'b1;
    logic                  awmf_sdi_i = 1'b0;
    logic                  awmf_pdi_i = 1'b0;
    logic                  awmf_ldb_i = 1'b0;
    logic                  awmf_sdo_o;
    logic [FRAME_BITS-1:0] latch_data_o;
    logic                  latch_vld_o;
    logic                  frame_done_o;
    logic                  frame_err_o;
    logic                  rd_frame_o;
    logic [CNT_W-1:0]      bit_cnt_o;

    awmf0165_chain_responder dut (
        .clk_20m(clk_20m), .rst(rst),
        .awmf_clk_i(awmf_clk_i), .awmf_csb_i(awmf_csb_i), .awmf_sdi_i(awmf_sdi_i),
        .awmf_pdi_i(awmf_pdi_i), .awmf_ldb_i(awmf_ldb_i), .awmf_sdo_o(awmf_sdo_o),
        .latch_data_o(latch_data_o), .latch_vld_o(latch_vld_o),
        .frame_done_o(frame_done_o), .frame_err_o(frame_err_o),
        .rd_frame_o(rd_frame_o), .bit_cnt_o(bit_cnt_o)
    );

    always #25 clk_20m = ~clk_20m;

    localparam logic [239:0] PAT_A5 = {30{8'hA5}};
    localparam logic [239:0] PAT_B  = {10{24'hC35A0F}};

    int nvec = 0;
    int nerr = 0;
    int vld_cnt = 0;
    int done_cnt = 0;
    logic [299:0] tx_vec = '0;
    logic [299:0] rx_vec = '0;

    // count pulse cycles away from the active edge
    always @(negedge clk_20m) begin
        if (latch_vld_o === 1'b1) vld_cnt = vld_cnt + 1;
        if (frame_done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_20m);
        #1;
    endtask

    task automatic start_frame(input logic pdi);
        awmf_pdi_i = pdi;
        awmf_csb_i = 1'b0;
        tick(6);
    endtask

    // each bit: sdi set with clk low, 4 cycles, clk high (sdo sampled), 4 cycles, clk low
    task automatic shift_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            awmf_sdi_i = tx_vec[nbits-1-i];
            tick(4);
            awmf_clk_i = 1'b1;
            rx_vec[nbits-1-i] = awmf_sdo_o;
            tick(4);
            awmf_clk_i = 1'b0;
        end
    endtask

    task automatic end_frame();
        tick(4);
        awmf_csb_i = 1'b1;
        tick(6);
    endtask

    task automatic ldb_pulse();
        awmf_ldb_i = 1'b1;
        tick(4);
        awmf_ldb_i = 1'b0;
        tick(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        nvec++; if (latch_data_o !== 240'h0) begin nerr++; $display("FAIL reset_latch got %h exp 0", latch_data_o); end
        nvec++; if ({awmf_sdo_o, latch_vld_o, frame_done_o, frame_err_o, rd_frame_o} !== 5'b0) begin
            nerr++; $display("FAIL reset_flags got %b exp 00000", {awmf_sdo_o, latch_vld_o, frame_done_o, frame_err_o, rd_frame_o}); end
        nvec++; if (bit_cnt_o !== 9'd0) begin nerr++; $display("FAIL reset_bitcnt got %0d exp 0", bit_cnt_o); end
        rst = 1'b0;
        tick(6);
        nvec++; if (vld_cnt !== 0 || done_cnt !== 0) begin nerr++; $display("FAIL reset_pulses got vld=%0d done=%0d exp 0 0", vld_cnt, done_cnt); end
    endtask

    task automatic test_write_good();
        int d0, v0;
        d0 = done_cnt; v0 = vld_cnt;
        tx_vec = '0; tx_vec[239:0] = PAT_A5;
        start_frame(1'b0); shift_bits(240); end_frame();
        nvec++; if (done_cnt !== d0 + 1) begin nerr++; $display("FAIL wr_done got %0d exp %0d", done_cnt - d0, 1); end
        nvec++; if (frame_err_o !== 1'b0) begin nerr++; $display("FAIL wr_err got %b exp 0", frame_err_o); end
        nvec++; if (bit_cnt_o !== 9'd240) begin nerr++; $display("FAIL wr_bitcnt got %0d exp 240", bit_cnt_o); end
        nvec++; if (rd_frame_o !== 1'b0) begin nerr++; $display("FAIL wr_rdframe got %b exp 0", rd_frame_o); end
        ldb_pulse();
        nvec++; if (latch_data_o !== PAT_A5) begin nerr++; $display("FAIL wr_latch got %h exp %h", latch_data_o, PAT_A5); end
        nvec++; if (vld_cnt !== v0 + 1) begin nerr++; $display("FAIL wr_vld got %0d exp 1", vld_cnt - v0); end
    endtask

    task automatic test_underflow();
        int d0;
        d0 = done_cnt;
        tx_vec = '0; tx_vec[238:0] = PAT_B[238:0];
        start_frame(1'b0); shift_bits(239); end_frame();
        nvec++; if (done_cnt !== d0 + 1) begin nerr++; $display("FAIL uf_done got %0d exp 1", done_cnt - d0); end
        nvec++; if (frame_err_o !== 1'b1) begin nerr++; $display("FAIL uf_err got %b exp 1", frame_err_o); end
        nvec++; if (bit_cnt_o !== 9'd239) begin nerr++; $display("FAIL uf_bitcnt got %0d exp 239", bit_cnt_o); end
        // zero-length frame
        start_frame(1'b0); end_frame();
        nvec++; if (frame_err_o !== 1'b1 || bit_cnt_o !== 9'd0) begin
            nerr++; $display("FAIL zero_len got err=%b cnt=%0d exp err=1 cnt=0", frame_err_o, bit_cnt_o); end
        // next good frame clears the error at csb fall
        tx_vec = '0; tx_vec[239:0] = PAT_B;
        start_frame(1'b0);
        nvec++; if (frame_err_o !== 1'b0 || bit_cnt_o !== 9'd0) begin
            nerr++; $display("FAIL err_clear got err=%b cnt=%0d exp err=0 cnt=0", frame_err_o, bit_cnt_o); end
        shift_bits(240); end_frame();
        nvec++; if (frame_err_o !== 1'b0) begin nerr++; $display("FAIL good_after_uf got %b exp 0", frame_err_o); end
        ldb_pulse();
        nvec++; if (latch_data_o !== PAT_B) begin nerr++; $display("FAIL latch_b got %h exp %h", latch_data_o, PAT_B); end
    endtask

    task automatic test_read();
        tx_vec = '0; rx_vec = '0;
        start_frame(1'b1);
        nvec++; if (rd_frame_o !== 1'b1) begin nerr++; $display("FAIL rd_flag got %b exp 1", rd_frame_o); end
        shift_bits(240); end_frame();
        nvec++; if (rx_vec[239:0] !== PAT_B) begin nerr++; $display("FAIL rd_stream got %h exp %h", rx_vec[239:0], PAT_B); end
        nvec++; if (frame_err_o !== 1'b0 || bit_cnt_o !== 9'd240) begin
            nerr++; $display("FAIL rd_status got err=%b cnt=%0d exp err=0 cnt=240", frame_err_o, bit_cnt_o); end
        nvec++; if (latch_data_o !== PAT_B) begin nerr++; $display("FAIL rd_latch_kept got %h exp %h", latch_data_o, PAT_B); end
    endtask

    task automatic test_ldb_in_frame();
        int v0;
        v0 = vld_cnt;
        tx_vec = '0;
        start_frame(1'b0); shift_bits(10);
        ldb_pulse();
        nvec++; if (vld_cnt !== v0) begin nerr++; $display("FAIL ldb_ign_vld got %0d exp 0", vld_cnt - v0); end
        nvec++; if (latch_data_o !== PAT_B) begin nerr++; $display("FAIL ldb_ign_latch got %h exp %h", latch_data_o, PAT_B); end
        end_frame();
        nvec++; if (frame_err_o !== 1'b1 || bit_cnt_o !== 9'd10) begin
            nerr++; $display("FAIL short_status got err=%b cnt=%0d exp err=1 cnt=10", frame_err_o, bit_cnt_o); end
    endtask

    task automatic test_overflow();
        int v0;
        v0 = vld_cnt;
        tx_vec = '0; tx_vec[249:240] = 10'h3FF; rx_vec = '0;
        start_frame(1'b0); shift_bits(250); end_frame();
        nvec++; if (rx_vec[9:0] !== 10'h3FF) begin nerr++; $display("FAIL ovf_sdo got %h exp 3ff", rx_vec[9:0]); end
        nvec++; if (frame_err_o !== 1'b1 || bit_cnt_o !== 9'd250) begin
            nerr++; $display("FAIL ovf_status got err=%b cnt=%0d exp err=1 cnt=250", frame_err_o, bit_cnt_o); end
        ldb_pulse();
        nvec++; if (latch_data_o !== 240'h0) begin nerr++; $display("FAIL ovf_latch got %h exp 0", latch_data_o); end
        nvec++; if (vld_cnt !== v0 + 1) begin nerr++; $display("FAIL ovf_vld got %0d exp 1", vld_cnt - v0); end
    endtask

    task automatic test_reset_mid();
        int d0;
        // put non-zero state in the latch first
        tx_vec = '0; tx_vec[239:0] = PAT_B;
        start_frame(1'b0); shift_bits(240); end_frame(); ldb_pulse();
        tx_vec = '0; tx_vec[239:0] = PAT_A5;
        start_frame(1'b1); shift_bits(100);
        rst = 1'b1;
        tick(1);
        nvec++; if (latch_data_o !== 240'h0 || bit_cnt_o !== 9'd0) begin
            nerr++; $display("FAIL rstmid_data got latch=%h cnt=%0d exp 0 0", latch_data_o, bit_cnt_o); end
        nvec++; if ({awmf_sdo_o, latch_vld_o, frame_done_o, frame_err_o, rd_frame_o} !== 5'b0) begin
            nerr++; $display("FAIL rstmid_flags got %b exp 00000", {awmf_sdo_o, latch_vld_o, frame_done_o, frame_err_o, rd_frame_o}); end
        rst = 1'b0;
        d0 = done_cnt;
        shift_bits(140); end_frame();
        nvec++; if (done_cnt !== d0 || bit_cnt_o !== 9'd0) begin
            nerr++; $display("FAIL rstmid_ignore got done=%0d cnt=%0d exp 0 0", done_cnt - d0, bit_cnt_o); end
        start_frame(1'b0); shift_bits(240); end_frame(); ldb_pulse();
        nvec++; if (latch_data_o !== PAT_A5 || frame_err_o !== 1'b0) begin
            nerr++; $display("FAIL rstmid_after got latch=%h err=%b exp %h 0", latch_data_o, frame_err_o, PAT_A5); end
    endtask

    initial begin
        test_reset();
        test_write_good();
        test_underflow();
        test_read();
        test_ldb_in_frame();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
